// File: rtl/f8_fetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package f8_fetch_pkg;

  localparam int MAX_HEAD_BYTES = 4;

  typedef logic [15:0] addr_t;   // byte address
  typedef logic [14:0] waddr_t;  // ROM bank word address
  typedef logic [7:0]  byte_t;

  // Even-bank word holding the second byte when the fetch starts on an odd byte.
  // Wraps modulo 2^15, so byte 0xFFFF pairs with even word 0.
  function automatic waddr_t even_word(addr_t a);
    return a[15:1] + waddr_t'(a[0]);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Byte shift queue: pop 0..4 from the head, push 0 or 2 bytes at the tail
// (after the pop) in the same edge, flush clears everything.
module fetch_queue
  import f8_fetch_pkg::*;
#(
  parameter  int QDEPTH = 6,
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  byte_t [1:0]              push_data,   // [0] lands first
  input  logic  [2:0]              pop,
  output logic  [CW-1:0]           count,
  output logic  [8*MAX_HEAD_BYTES-1:0] head_bytes,
  output logic  [2:0]              head_count
);

  localparam int W = 8 * QDEPTH;

  byte_t [QDEPTH-1:0] q;
  logic  [W-1:0]      shifted, keep_mask, ins, q_next;
  logic  [CW-1:0]     tail, cnt_next;

  // Next queue image: shift out popped bytes, then drop the new pair at the tail.
  // Masking above the tail keeps stale bytes from ever merging with pushed ones.
  always_comb begin
    tail      = count - CW'(pop);
    shifted   = q >> {pop, 3'b000};
    keep_mask = ~({W{1'b1}} << {tail, 3'b000});
    ins       = W'(push_data) << {tail, 3'b000};
    q_next    = push ? ((shifted & keep_mask) | ins) : shifted;
    cnt_next  = push ? (tail + CW'(2)) : tail;
    if (flush) begin
      q_next   = '0;
      cnt_next = '0;
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q     <= '0;
      count <= '0;
    end else begin
      q     <= q_next;
      count <= cnt_next;
    end
  end

  // Head view: at most four bytes, lanes beyond the valid count read as zero.
  always_comb begin
    head_count = (count >= CW'(MAX_HEAD_BYTES)) ? 3'(MAX_HEAD_BYTES) : 3'(count);
    head_bytes = '0;
    for (int i = 0; i < MAX_HEAD_BYTES; i++)
      if (3'(i) < head_count) head_bytes[8*i +: 8] = q[i];
  end

endmodule

// File: rtl/ifetch.sv
// Instruction prefetch: drives both ROM banks for a two-byte read at any
// alignment, captures the returned pair a cycle later into the byte queue,
// and tracks the byte address of the queue head for the decoder.
module ifetch
  import f8_fetch_pkg::*;
#(
  parameter addr_t RESET_ADDR = 16'h4000,
  parameter int    QDEPTH     = 6          // >= 4 and even
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic [14:0]  read_addr_even,
  input  logic [7:0]   read_data_even,
  output logic [14:0]  read_addr_odd,
  input  logic [7:0]   read_data_odd,
  input  logic         redirect,
  input  logic [15:0]  redirect_addr,
  output logic [31:0]  out_bytes,
  output logic [2:0]   out_count,
  output logic [15:0]  head_addr,
  input  logic [2:0]   consume
);

  localparam int CW = $clog2(QDEPTH + 1);

  addr_t          fetch_addr;
  logic           pending, pending_odd;
  logic           issue;
  logic [CW-1:0]  q_count;
  byte_t [1:0]    push_data;

  // Both banks are addressed every cycle; the odd bank always holds byte A or A+1
  // at word A>>1, the even bank steps to the next word on odd alignment.
  assign read_addr_odd  = fetch_addr[15:1];
  assign read_addr_even = even_word(fetch_addr);

  // Issue only when the queue can absorb this read plus one still in flight,
  // ignoring this cycle's pop so no ROM data ever needs to be throttled.
  always_comb begin
    issue = !redirect &&
            ((int'(q_count) + (pending ? 2 : 0) + 2) <= QDEPTH);
  end

  // Returned pair in byte order: the lower byte address goes first.
  assign push_data = pending_odd ? {read_data_even, read_data_odd}
                                 : {read_data_odd,  read_data_even};

  // Fetch pointer, in-flight tracking and head address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr  <= RESET_ADDR;
      head_addr   <= RESET_ADDR;
      pending     <= 1'b0;
      pending_odd <= 1'b0;
    end else if (redirect) begin
      fetch_addr  <= redirect_addr;
      head_addr   <= redirect_addr;
      pending     <= 1'b0;
    end else begin
      head_addr <= head_addr + addr_t'(consume);
      if (issue) begin
        fetch_addr  <= fetch_addr + 16'd2;
        pending     <= 1'b1;
        pending_odd <= fetch_addr[0];
      end else begin
        pending <= 1'b0;
      end
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect),
    .push       (pending && !redirect),
    .push_data  (push_data),
    .pop        (redirect ? 3'd0 : consume),
    .count      (q_count),
    .head_bytes (out_bytes),
    .head_count (out_count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a one-cycle synchronous dual-bank ROM model
// whose byte at address a is a[7:0]^8'h5A.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] read_addr_even, read_addr_odd;
  logic [7:0]  read_data_even, read_data_odd;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic [31:0] out_bytes;
  logic [2:0]  out_count;
  logic [15:0] head_addr;
  logic [2:0]  consume;

  int n_cmp = 0;
  int n_err = 0;

  ifetch #(.RESET_ADDR(16'h4000), .QDEPTH(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .read_addr_even (read_addr_even),
    .read_data_even (read_data_even),
    .read_addr_odd  (read_addr_odd),
    .read_data_odd  (read_data_odd),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .out_bytes      (out_bytes),
    .out_count      (out_count),
    .head_addr      (head_addr),
    .consume        (consume)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // ROM banks: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    read_data_even <= rom({read_addr_even, 1'b0});
    read_data_odd  <= rom({read_addr_odd,  1'b1});
  end

  // The decoder must never pop more than is shown.
  always @(negedge clk) begin
    if (reset_n === 1'b1)
      assert (consume <= out_count) else begin
        n_err++;
        $error("FAIL consume_legal: consume %0d out_count %0d", consume, out_count);
      end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] h;
    reset_n = 1'b0; redirect = 1'b0; redirect_addr = '0; consume = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_bytes", out_bytes, 32'h0);
    chk("rst_head",  32'(head_addr), 32'h4000);
    chk("rst_even",  32'(read_addr_even), 32'h2000);
    chk("rst_odd",   32'(read_addr_odd),  32'h2000);

    // Fill from reset with no consumption.
    reset_n = 1'b1;
    step(); chk("fill_c1_count", 32'(out_count), 32'd0);
    step(); chk("fill_c2_count", 32'(out_count), 32'd2);
            chk("fill_c2_bytes", out_bytes, 32'h00005B5A);
            chk("fill_c2_head",  32'(head_addr), 32'h4000);
    step(); chk("fill_c3_count", 32'(out_count), 32'd4);
            chk("fill_c3_bytes", out_bytes, 32'h59585B5A);
            chk("fill_c3_odd",   32'(read_addr_odd), 32'h2003);
    step(); step();
            chk("fill_hold_even", 32'(read_addr_even), 32'h2003);
            chk("fill_hold_odd",  32'(read_addr_odd),  32'h2003);
            chk("fill_hold_count", 32'(out_count), 32'd4);

    // Redirect to an odd byte address.
    redirect = 1'b1; redirect_addr = 16'h4001;
    step(); redirect = 1'b0;
            chk("rd1_even",  32'(read_addr_even), 32'h2001);
            chk("rd1_odd",   32'(read_addr_odd),  32'h2000);
            chk("rd1_count", 32'(out_count), 32'd0);
            chk("rd1_head",  32'(head_addr), 32'h4001);
    step(); chk("rd1_t2_count", 32'(out_count), 32'd0);
    step(); chk("rd1_t3_count", 32'(out_count), 32'd2);
            chk("rd1_t3_bytes", out_bytes, 32'h0000585B);
    step(); chk("rd1_t4_bytes", out_bytes, 32'h5E59585B);

    // Redirect colliding with a capture and a 3-byte pop.
    redirect = 1'b1; redirect_addr = 16'h4000; consume = 3'd3;
    step(); redirect = 1'b0; consume = 3'd0;
            chk("rdcol_count", 32'(out_count), 32'd0);
            chk("rdcol_head",  32'(head_addr), 32'h4000);
    step(); chk("rdcol_t2_count", 32'(out_count), 32'd0);
    step(); chk("rdcol_t3_count", 32'(out_count), 32'd2);
            chk("rdcol_t3_bytes", out_bytes, 32'h00005B5A);

    // Steady drain of two bytes per cycle: one read issued every cycle.
    consume = 3'd2;
    for (int k = 1; k <= 6; k++) begin
      step();
      h = 16'h4000 + 16'(2 * k);
      chk("steady_head",  32'(head_addr), 32'(h));
      chk("steady_count", 32'(out_count), 32'd2);
      chk("steady_bytes", out_bytes, {16'h0, rom(h + 16'd1), rom(h)});
      chk("steady_odd",   32'(read_addr_odd), 32'((h + 16'd4) >> 1));
    end

    // Asynchronous reset with a read in flight.
    consume = 3'd0; reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(out_count), 32'd0);
    chk("arst_head",  32'(head_addr), 32'h4000);
    chk("arst_bytes", out_bytes, 32'h0);
    chk("arst_odd",   32'(read_addr_odd), 32'h2000);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    step(); chk("arst_c1_count", 32'(out_count), 32'd0);
    step(); chk("arst_c2_count", 32'(out_count), 32'd2);
            chk("arst_c2_bytes", out_bytes, 32'h00005B5A);
            chk("arst_c2_head",  32'(head_addr), 32'h4000);

    // Redirect to the top of the address space.
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    step(); redirect = 1'b0;
            chk("wrap_odd",  32'(read_addr_odd),  32'h7FFF);
            chk("wrap_even", 32'(read_addr_even), 32'h0000);
    step(); step();
            chk("wrap_count", 32'(out_count), 32'd2);
            chk("wrap_bytes", out_bytes, 32'h00005AA5);
            chk("wrap_head",  32'(head_addr), 32'hFFFF);
    consume = 3'd1;
    step(); consume = 3'd0;
            chk("wrap_pop_head",  32'(head_addr), 32'h0000);
            chk("wrap_pop_count", 32'(out_count), 32'd3);
            chk("wrap_pop_bytes", out_bytes, 32'h00585B5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
